wave_capture: RTL

- Writer side of the wave display sample RAM.
- Watches the audio sample stream and arms on a rising zero crossing.
- Captures 256 consecutive samples into the RAM half not currently being displayed. When the display reports idle, it flips `read_index` so `wave_display` shows the new capture.
- Sits between the codec/sample source and the dual-ported wave RAM feeding `wave_display`.

---
 rtl/wave_pkg.sv | 23 ++
 rtl/zero_cross_detect.sv | 22 ++
 rtl/wave_capture.sv | 90 +++++++++
 3 files changed

// File: rtl/wave_pkg.sv
// Shared wave-display definitions: capture geometry, capture FSM states and
// the signed-to-offset-binary sample conversion used by capture and display.
package wave_pkg;

  localparam int unsigned SAMPLE_W     = 16;
  localparam int unsigned CAP_LEN_LOG2 = 8;
  localparam int unsigned ADDR_W       = CAP_LEN_LOG2 + 1;
  localparam int unsigned PIX_W        = 8;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } cap_state_e;

  // Top eight bits of a signed sample, sign bit flipped to offset binary.
  function automatic logic [PIX_W-1:0] to_offset8(input logic [SAMPLE_W-1:0] s);
    logic unused_low_bits;
    unused_low_bits = ^s[SAMPLE_W-PIX_W-1:0];
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:SAMPLE_W-PIX_W]};
  endfunction

endpackage

// File: rtl/zero_cross_detect.sv
// Flags a negative-to-nonnegative transition between consecutive strobed samples.
module zero_cross_detect (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic msb,
  output logic rise_c
);

  logic prev_neg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_neg <= 1'b0;
    end else if (strobe) begin
      prev_neg <= msb;
    end
  end

  assign rise_c = strobe & prev_neg & ~msb;

endmodule

// File: rtl/wave_capture.sv
// Writer side of the double-buffered wave RAM: arms on a rising zero crossing,
// captures one buffer of samples into the hidden half, then swaps halves when the display is idle.
module wave_capture
  import wave_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [ADDR_W-1:0]   write_address,
  output logic                write_enable,
  output logic [PIX_W-1:0]    write_sample,
  output logic                read_index
);

  cap_state_e              state_q, state_d;
  logic [CAP_LEN_LOG2-1:0] count_q, count_d;
  logic [ADDR_W-1:0]       addr_d;
  logic                    we_d;
  logic [PIX_W-1:0]        sample_d;
  logic                    read_index_d;
  logic                    rise_c;

  zero_cross_detect u_zero_cross (
    .clk    (clk),
    .reset  (reset),
    .strobe (new_sample_ready),
    .msb    (new_sample_in[SAMPLE_W-1]),
    .rise_c (rise_c)
  );

  // Next-state and next-output decode
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    addr_d       = write_address;
    we_d         = 1'b0;
    sample_d     = write_sample;
    read_index_d = read_index;
    case (state_q)
      ARMED: begin
        if (rise_c) begin
          state_d = ACTIVE;
          count_d = '0;
        end
      end
      ACTIVE: begin
        if (new_sample_ready) begin
          we_d     = 1'b1;
          addr_d   = {~read_index, count_q};
          sample_d = to_offset8(new_sample_in);
          count_d  = CAP_LEN_LOG2'(count_q + 1'b1);
          if (count_q == '1) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (wave_display_idle) begin
          read_index_d = ~read_index;
          state_d      = ARMED;
        end
      end
      default: begin
        state_d = ARMED;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ARMED;
      count_q       <= '0;
      write_address <= '0;
      write_enable  <= 1'b0;
      write_sample  <= '0;
      read_index    <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      write_address <= addr_d;
      write_enable  <= we_d;
      write_sample  <= sample_d;
      read_index    <= read_index_d;
    end
  end

endmodule
